// File: rtl/bus_sram_responder.sv
// bus_sram_responder: bus slave that serves burst reads and burst writes
// out of a local 2^ADDR_BITS x 32-bit word SRAM.
// Optional feature macro: BUS_SRAM_RESPONDER_WRAP_ERROR_EN.
//   defined   -> a burst whose last word runs past the top of memory is refused
//                at the address phase (ERROR pulse, no memory access)
//   undefined -> the word pointer wraps modulo 2^ADDR_BITS
// Handshake: the initiator holds beginTransactionIn for one cycle in the
// address phase. After that, the responder does not stall writes: each cycle
// with dataValidIn=1 is one write word. Read words are pushed on dataValidOut
// with no back-pressure, and endTransactionOut closes the read burst.
// debug_state_out exposes the FSM state (IDLE=0, RD_FETCH=1, RD_DATA=2,
// RD_END=3, WR_DATA=4, ERROR=5).
module bus_sram_responder #(
   parameter logic [31:0] BASE_ADDRESS = 32'h0000_4000,
   parameter int          ADDR_BITS    = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        beginTransactionIn,
   input  logic [31:0] addressDataIn,
   input  logic        readNotWriteIn,
   input  logic [7:0]  burstSizeIn,
   input  logic [3:0]  byteEnablesIn,
   input  logic        dataValidIn,
   input  logic        endTransactionIn,
   output logic [31:0] addressDataOut,
   output logic        dataValidOut,
   output logic        endTransactionOut,
   output logic        busyOut,
   output logic        busErrorOut,
   output logic [2:0]  debug_state_out
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_FETCH = 3'd1,
      S_RD_DATA  = 3'd2,
      S_RD_END   = 3'd3,
      S_WR_DATA  = 3'd4,
      S_ERROR    = 3'd5
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_BITS-1:0]  ptr_q, ptr_d;
   logic [7:0]            cnt_q, cnt_d;    // words remaining minus one
   logic [3:0]            be_q, be_d;
   logic                  done_q, done_d;  // last write word already accepted
   logic                  overrun_q, overrun_d;
   logic [31:0]           rd_data_q;
   logic [31:0]           mem [DEPTH];

   logic                  sel;
   logic                  aligned;
   logic                  wrap_bad;
   logic                  wr_en;

   assign sel     = beginTransactionIn &&
                    (addressDataIn[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
   assign aligned = (addressDataIn[1:0] == 2'b00);

`ifdef BUS_SRAM_RESPONDER_WRAP_ERROR_EN
   localparam int LW = ADDR_BITS + 9;
   logic [LW-1:0] last_idx;
   // Index of the last word of the requested burst, wide enough not to wrap
   always_comb begin
      last_idx = LW'(addressDataIn[ADDR_BITS+1:2]) + LW'(burstSizeIn);
      wrap_bad = (last_idx > LW'(DEPTH - 1));
   end
`else
   assign wrap_bad = 1'b0;
`endif

   // State and control registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         cnt_q     <= '0;
         be_q      <= '0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         be_q      <= be_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   // Next state, pointer/count bookkeeping and write strobe
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      be_d      = be_q;
      done_d    = done_q;
      overrun_d = 1'b0;
      wr_en     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sel) begin
               if (!aligned || wrap_bad) begin
                  state_d = S_ERROR;
               end else begin
                  ptr_d   = addressDataIn[ADDR_BITS+1:2];
                  cnt_d   = burstSizeIn;
                  be_d    = byteEnablesIn;
                  done_d  = 1'b0;
                  state_d = readNotWriteIn ? S_RD_FETCH : S_WR_DATA;
               end
            end
         end
         S_RD_FETCH: state_d = S_RD_DATA;
         S_RD_DATA: begin
            if (cnt_q == 8'd0) begin
               state_d = S_RD_END;
            end else begin
               cnt_d = cnt_q - 8'd1;
               ptr_d = ptr_q + 1'b1;
            end
         end
         S_RD_END: state_d = S_IDLE;
         S_WR_DATA: begin
            if (dataValidIn) begin
               if (!done_q) begin
                  wr_en = !reset;
                  ptr_d = ptr_q + 1'b1;
                  if (cnt_q == 8'd0) done_d = 1'b1;
                  else               cnt_d  = cnt_q - 8'd1;
               end else begin
                  overrun_d = 1'b1;
               end
            end
            if (endTransactionIn) state_d = S_IDLE;
         end
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // SRAM: byte-masked write at the current pointer, registered read of the
   // next pointer so the word is ready one cycle later
   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[ptr_q][8*b +: 8] <= addressDataIn[8*b +: 8];
         end
      end
      rd_data_q <= mem[ptr_d];
   end

   // Bus outputs decoded from the state
   always_comb begin
      addressDataOut    = 32'd0;
      dataValidOut      = 1'b0;
      endTransactionOut = 1'b0;
      busyOut           = 1'b0;
      busErrorOut       = overrun_q;
      debug_state_out   = state_q;
      case (state_q)
         S_RD_FETCH: busyOut = 1'b1;
         S_RD_DATA: begin
            dataValidOut   = 1'b1;
            addressDataOut = rd_data_q;
         end
         S_RD_END:  endTransactionOut = 1'b1;
         S_ERROR:   busErrorOut = 1'b1;
         default: ;
      endcase
   end

endmodule
